// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential unsigned divider.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of bits needed to count 0 .. value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell used to build the ripple borrow chain.
module full_subtractor (
    output logic Diff,
    output logic Bout,
    input  logic A,
    input  logic B,
    input  logic Bin
);

    logic a_xor_b;

    assign a_xor_b = A ^ B;
    assign Diff    = a_xor_b ^ Bin;
    assign Bout    = (~A & B) | (~a_xor_b & Bin);

endmodule

// File: rtl/div_unsigned_seq.sv
// Restoring unsigned divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
module div_unsigned_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic                 div_err,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder
);

    localparam int unsigned RW    = WIDTH + 1;
    localparam int unsigned CNT_W = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [RW-1:0]      r_q, r_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [2*WIDTH:0]   rq_sh_c;
    logic [RW-1:0]      sub_a_c;
    logic [RW-1:0]      sub_b_c;
    logic [RW-1:0]      diff_c;
    logic [RW:0]        borrow_c;
    logic               err_c;

    // Partial remainder and quotient shifted left as one register pair.
    assign rq_sh_c = {r_q, q_q} << 1;
    assign sub_a_c = rq_sh_c[2*WIDTH:WIDTH];
    assign sub_b_c = {1'b0, dvs_q};

    // A high half >= divisor would produce a quotient wider than WIDTH bits.
    assign err_c = (divisor == '0) || (dividend[2*WIDTH-1:WIDTH] >= divisor);

    assign borrow_c[0] = 1'b0;
    for (genvar i = 0; i < RW; i++) begin : g_sub
        full_subtractor u_fs (
            .Diff (diff_c[i]),
            .Bout (borrow_c[i+1]),
            .A    (sub_a_c[i]),
            .B    (sub_b_c[i]),
            .Bin  (borrow_c[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvs_d = divisor;
                    r_d   = {1'b0, dividend[2*WIDTH-1:WIDTH]};
                    q_d   = dividend[WIDTH-1:0];
                    cnt_d = '0;
                    if (err_c) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        quo_d   = '0;
                        rem_d   = '0;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                    end
                end
            end

            ST_RUN: begin
                // No final borrow means the divisor fits: keep the difference, set the bit.
                if (!borrow_c[RW]) begin
                    r_d = diff_c;
                    q_d = {rq_sh_c[WIDTH-1:1], 1'b1};
                end else begin
                    r_d = rq_sh_c[2*WIDTH:WIDTH];
                    q_d = rq_sh_c[WIDTH-1:0];
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div_err   = err_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_div_unsigned_seq.sv
// Self-checking bench for div_unsigned_seq: arithmetic reference model plus directed and random divides.
module tb_div_unsigned_seq;

    localparam int unsigned W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic             busy;
    logic             done;
    logic             div_err;
    logic [W-1:0]     quotient;
    logic [W-1:0]     remainder;

    int checks = 0;
    int errors = 0;

    div_unsigned_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_err   (div_err),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain / and %, with a countdown for the result latency.
    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic           m_err  = 1'b0;
    logic [W-1:0]   m_q    = '0;
    logic [W-1:0]   m_r    = '0;
    logic [W-1:0]   p_q    = '0;
    logic [W-1:0]   p_r    = '0;
    int             m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        bit was_done;
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_q = '0; m_r = '0; m_left = 0;
        end else begin
            was_done = m_done;
            m_done   = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                end
            end else if (!was_done && start) begin
                if (divisor == 0 || dividend[2*W-1:W] >= divisor) begin
                    m_done = 1'b1;
                    m_err  = 1'b1;
                    m_q    = '0;
                    m_r    = '0;
                end else begin
                    m_left = W;
                    m_busy = 1'b1;
                    m_err  = 1'b0;
                    p_q    = W'(dividend / 32'(divisor));
                    p_r    = W'(dividend % 32'(divisor));
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy",      32'(busy),      32'(m_busy));
        chk("cyc_done",      32'(done),      32'(m_done));
        chk("cyc_div_err",   32'(div_err),   32'(m_err));
        chk("cyc_quotient",  32'(quotient),  32'(m_q));
        chk("cyc_remainder", 32'(remainder), 32'(m_r));
    end

    // Issue one divide and check latency and results against literal expectations.
    task automatic run_div(input string tag, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic ee,
                           input int elat);
        int lat;
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = W'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_latency"},   32'(lat),  32'(elat));
        chk({tag, "_quotient"},  32'(quotient),  32'(eq));
        chk({tag, "_remainder"}, 32'(remainder), 32'(er));
        chk({tag, "_div_err"},   32'(div_err),   32'(ee));
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ndone, dlat;
        logic [W-1:0] gq, gr, dvs, hi, lo;
        logic [2*W-1:0] dvd;
        logic e;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_div_err",   32'(div_err),   32'd0);
        chk("rst_quotient",  32'(quotient),  32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("d100_7",  32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 17);
        run_div("dmax",    32'hFFFE_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 17);
        run_div("dovf",    32'h0005_0000, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1);
        run_div("dzero",   32'h1234_5678, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1);
        run_div("dclear",  32'h0001_0000, 16'h0002, 16'h8000, 16'h0000, 1'b0, 17);

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        dividend = 32'h0000_0064;
        divisor  = 16'h0007;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; dlat = 0; gq = '0; gr = '0;
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                ndone++;
                dlat = c;
                gq = quotient;
                gr = remainder;
            end
            start = (c == 5);
            if (c == 5) begin
                dividend = 32'h0001_0000;
                divisor  = 16'h0002;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_start_done_count", 32'(ndone), 32'd1);
        chk("busy_start_latency",    32'(dlat),  32'd17);
        chk("busy_start_quotient",   32'(gq),    32'h000E);
        chk("busy_start_remainder",  32'(gr),    32'h0002);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        dividend = 32'h0000_0064;
        divisor  = 16'h0007;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_done",      32'(done),      32'd0);
        chk("mid_rst_div_err",   32'(div_err),   32'd0);
        chk("mid_rst_quotient",  32'(quotient),  32'd0);
        chk("mid_rst_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_div("post_rst", 32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 17);

        // Random divides, mostly legal, with some zero divisors and overflows.
        for (int n = 0; n < 40; n++) begin
            dvs = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 65535));
            if ($urandom_range(0, 3) == 0 || dvs == '0) hi = W'($urandom);
            else hi = W'($urandom % 32'(dvs));
            lo  = W'($urandom);
            dvd = {hi, lo};
            e   = (dvs == '0) || (hi >= dvs);
            if (e) run_div("rand_err", dvd, dvs, '0, '0, 1'b1, 1);
            else   run_div("rand", dvd, dvs, W'(dvd / 32'(dvs)), W'(dvd % 32'(dvs)), 1'b0, 17);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
